// File: rtl/m68k_bus_initiator.sv
// m68k_bus_initiator: turns a valid/ready request into a 68000-style asynchronous bus cycle.
// Optional macro M68K_BUS_TIMEOUT_EN: abort WAIT after TIMEOUT cycles with an error response.
module m68k_bus_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [22:0] req_addr,
    input  logic [1:0]  req_be,
    input  logic [2:0]  req_fc,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_vpa,
    output logic        as_n,
    output logic        uds_n,
    output logic        lds_n,
    output logic        rw,
    output logic [2:0]  fc,
    output logic [22:0] addr,
    output logic [15:0] dout,
    input  logic [15:0] din,
    input  logic        dtack_n,
    input  logic        vpa_n,
    input  logic        berr_n
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_STROBE, ST_WAIT, ST_LATCH, ST_RELEASE
    } state_t;

    state_t      r_state, w_next;
    logic        r_live, r_rw, r_err, r_vpa;
    logic [1:0]  r_be;
    logic [22:0] r_addr;
    logic [2:0]  r_fc;
    logic [15:0] r_dout, r_rdata;
    logic        r_rsp_valid, r_rsp_err, r_rsp_vpa;
    logic        w_accept, w_null, w_term, w_term_err, w_term_vpa, w_bus_quiet, w_timeout;

    assign req_ready   = r_live && (r_state == ST_IDLE);
    assign w_accept    = req_valid && req_ready;
    assign w_null      = (req_be == 2'b00);
    assign w_bus_quiet = dtack_n && vpa_n && berr_n;
    assign w_term      = !berr_n || !dtack_n || !vpa_n || w_timeout;
    // Only meaningful when w_term: BERR wins, otherwise an error means the timeout fired alone.
    assign w_term_err  = !berr_n || (dtack_n && vpa_n);
    assign w_term_vpa  = berr_n && dtack_n && !vpa_n;

`ifdef M68K_BUS_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (r_state != ST_WAIT)
            r_cnt <= '0;
        else if (r_cnt != TMAX)
            r_cnt <= r_cnt + CW'(1);
    end

    assign w_timeout = (r_state == ST_WAIT) && (r_cnt == TMAX);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept) w_next = w_null ? ST_RELEASE : ST_ADDR;
            ST_ADDR:    w_next = ST_STROBE;
            ST_STROBE:  w_next = ST_WAIT;
            ST_WAIT:    if (w_term) w_next = ST_LATCH;
            ST_LATCH:   w_next = ST_RELEASE;
            ST_RELEASE: if (w_bus_quiet) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Reads drop the data strobes with AS; writes hold them off until WAIT (bus S4).
    always_comb begin
        as_n  = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
        rw    = 1'b1;
        case (r_state)
            ST_ADDR: rw = r_rw;
            ST_STROBE: begin
                as_n = 1'b0;
                rw   = r_rw;
                if (r_rw) begin
                    uds_n = !r_be[1];
                    lds_n = !r_be[0];
                end
            end
            ST_WAIT, ST_LATCH: begin
                as_n  = 1'b0;
                rw    = r_rw;
                uds_n = !r_be[1];
                lds_n = !r_be[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_live      <= 1'b0;
            r_rw        <= 1'b1;
            r_be        <= '0;
            r_addr      <= '0;
            r_fc        <= '0;
            r_dout      <= '0;
            r_err       <= 1'b0;
            r_vpa       <= 1'b0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_vpa   <= 1'b0;
        end else begin
            r_live      <= 1'b1;
            r_rsp_valid <= 1'b0;
            if (w_accept && !w_null) begin
                r_rw   <= req_rw;
                r_be   <= req_be;
                r_addr <= req_addr;
                r_fc   <= req_fc;
                if (!req_rw) r_dout <= req_wdata;
            end
            if (w_accept && w_null) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_rsp_vpa   <= 1'b0;
            end
            if (r_state == ST_WAIT && w_term) begin
                r_err <= w_term_err;
                r_vpa <= w_term_vpa;
            end
            if (r_state == ST_LATCH) begin
                if (r_rw && !r_err) r_rdata <= din;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= r_err;
                r_rsp_vpa   <= r_vpa;
            end
        end
    end

    assign addr      = r_addr;
    assign fc        = r_fc;
    assign dout      = r_dout;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_rsp_err;
    assign rsp_vpa   = r_rsp_vpa;
endmodule

// File: doc/m68k_bus_initiator.md
# m68k_bus_initiator

- Bus master that runs 68000-style asynchronous bus cycles: AS_n, UDS_n/LDS_n, R/W, FC and a 23-bit word address.
- Terminates each cycle on DTACK_n, VPA_n or BERR_n from a memory-mapped responder.
- Lets non-CPU agents (test DMA, latency-probe sequencer) drive the same peripheral decode and acknowledge logic that normally serves the soft 68000.
- Turns a simple valid/ready request port into a full strobe sequence and returns one response per request.

## Interface
Parameters:
- TIMEOUT, 255: WAIT-state cycles before a cycle is aborted (needs `M68K_BUS_TIMEOUT_EN`); legal range 1..65535.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_rw  in  1  1 = read, 0 = write
- req_addr  in  23  word address (byte address [23:1])
- req_be  in  2  byte enables: [1] upper byte, [0] lower byte
- req_fc  in  3  function code
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  16  read data, held until next rsp_valid
- rsp_err  out  1  BERR, timeout or null-enable completion; qualified by rsp_valid
- rsp_vpa  out  1  cycle was terminated by VPA_n; qualified by rsp_valid
- as_n, uds_n, lds_n  out  1 each  bus strobes
- rw  out  1  bus direction
- fc  out  3  bus function code
- addr  out  23  bus word address
- dout  out  16  bus write data
- din  in  16  bus read data
- dtack_n, vpa_n, berr_n  in  1 each  cycle terminators

## Operation
- The state machine has six states: IDLE, ADDR, STROBE, WAIT, LATCH, RELEASE.
- IDLE
  - req_ready = 1.
  - When req_valid & req_ready: latch all req_* fields.
  - If req_be == 00: go to RELEASE with an error response and no strobes asserted.
  - Otherwise go to ADDR.
- ADDR: addr, fc and rw are driven from the latched request; dout is driven for writes; all strobes are high.
- STROBE
  - as_n = 0.
  - Reads: the enabled uds_n/lds_n go low in this same cycle.
  - Writes: the data strobes stay high in this cycle.
- WAIT
  - as_n = 0 and the enabled data strobes are low.
  - Termination is sampled every cycle, in this priority order:
    - berr_n = 0: err.
    - dtack_n = 0: normal.
    - vpa_n = 0: normal, with rsp_vpa = 1.
    - Timeout counter reaches TIMEOUT: err.
  - On any termination go to LATCH.
- LATCH: strobes are still asserted; for reads, din is captured into rsp_rdata.
- RELEASE
  - as_n, uds_n and lds_n go high; rw returns to 1.
  - rsp_valid pulses on the first RELEASE cycle.
  - Stay in RELEASE until dtack_n, vpa_n and berr_n are all high, then go to IDLE.
- On an error, rsp_rdata keeps its previous value.
- Bus outputs (addr, fc, dout) keep their last values in IDLE.

## Timing
- Reset values: req_ready = 0 while reset_n is low, then 1 on the first clock after release.
- All other outputs reset asynchronously:
  - as_n = uds_n = lds_n = 1, rw = 1.
  - fc = 0, addr = 0, dout = 0.
  - rsp_valid = 0, rsp_err = 0, rsp_vpa = 0, rsp_rdata = 0.
- Read with a zero-wait responder (DTACK_n low in the first WAIT cycle):
  - Accept at edge 0.
  - ADDR at 1, STROBE at 2, WAIT at 3, LATCH at 4.
  - RELEASE with rsp_valid at 5.
  - IDLE at 6 if terminators are already high, so there are 6 cycles between accepts.
- A write is the same length: the data strobes are first low in WAIT (the first WAIT cycle is bus S4).
- Timeout counter: clog2(TIMEOUT+1) bits, cleared on entry to WAIT, saturating.
- A timeout fires on the cycle where count == TIMEOUT with no terminator present.
- Reset asserted mid-cycle: strobes negate immediately; no response is issued for the aborted request.
- No back-to-back acceptance: at least one IDLE cycle always separates bus cycles.

## Configuration
- `M68K_BUS_TIMEOUT_EN` defined: the WAIT timeout is active and completes the cycle with rsp_err = 1.
- Not defined: the counter logic is removed, TIMEOUT is ignored, and WAIT holds indefinitely until a terminator arrives, matching real 68000 behaviour.

## Test plan
- Read, addr 0x080000 (byte 0x100000), be 11, responder returns 0xBEEF with DTACK in the first WAIT cycle:
  - rsp_rdata = 0xBEEF, err = 0.
  - rsp_valid exactly 5 cycles after accept.
  - as_n low for exactly 3 cycles.
- Write 0x1234 with be 01:
  - lds_n low and uds_n high throughout.
  - dout = 0x1234 stable from ADDR to RELEASE.
  - Data strobe first low the cycle after as_n first goes low.
- fc = 111 with vpa_n low at the 3rd WAIT cycle: rsp_vpa = 1, err = 0.
- berr_n and dtack_n low in the same cycle: rsp_err = 1, and rsp_rdata is unchanged from its previous value.
- With the macro defined and TIMEOUT = 4, no terminator:
  - rsp_err = 1 after 5 WAIT cycles.
  - Without the macro, the block is still in WAIT after 1000 cycles.
- reset_n pulled low during WAIT: as_n, uds_n and lds_n are high in the same cycle; no rsp_valid; req_ready = 1 on the first clock after release.
